// File: rtl/vga_layer_mixer_pkg.sv
// Shared types for the VGA layer mixer: RGB struct, fade FSM states, NONE-layer encoding.
package vga_mixer_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        STEADY   = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_e;

    localparam rgb_t BG_DEFAULT = 24'h6BE9F2;

    // "No layer" is encoded as the first index past the last real layer.
    function automatic int unsigned layer_none(input int unsigned n_layers);
        return n_layers;
    endfunction

endpackage

// File: rtl/vga_layer_mixer_if.sv
// Timing-generator/layer inputs and VGA outputs of the layer mixer.
// master = timing/layer source side, slave = mixer.
interface vga_layer_mixer_if #(
    parameter int unsigned N_LAYERS = 2,
    parameter int unsigned COLR_W   = 8
);
    localparam int unsigned SEL_W = $clog2(N_LAYERS + 1);

    logic                         i_hsync;
    logic                         i_vsync;
    logic                         i_de;
    logic                         i_frame;
    logic [N_LAYERS-1:0]          i_processing;
    logic [N_LAYERS-1:0]          i_drawing;
    logic [N_LAYERS*3*COLR_W-1:0] i_colr;
    logic                         vga_hsync;
    logic                         vga_vsync;
    logic                         vga_blank_n;
    logic                         vga_sync_n;
    logic [COLR_W-1:0]            vga_r;
    logic [COLR_W-1:0]            vga_g;
    logic [COLR_W-1:0]            vga_b;
    logic [SEL_W-1:0]             o_shown_layer;
    logic                         o_fading;

    modport master (
        output i_hsync, i_vsync, i_de, i_frame, i_processing, i_drawing, i_colr,
        input  vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b,
               o_shown_layer, o_fading
    );

    modport slave (
        input  i_hsync, i_vsync, i_de, i_frame, i_processing, i_drawing, i_colr,
        output vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b,
               o_shown_layer, o_fading
    );

endinterface

// File: rtl/vga_layer_mixer_fade_scaler.sv
// Pipeline stage 2: registered per-channel brightness scaling, out = (c * level) >> log2(FADE_FRAMES).
module vga_fade_scaler #(
    parameter int unsigned COLR_W      = 8,
    parameter int unsigned FADE_FRAMES = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3*COLR_W-1:0]               colr,
    input  logic [$clog2(FADE_FRAMES):0]      level,
    output logic [3*COLR_W-1:0]               scaled
);
    localparam int unsigned SH = $clog2(FADE_FRAMES);
    localparam int unsigned PW = COLR_W + SH + 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scaled <= '0;
        end else begin
            for (int unsigned ch = 0; ch < 3; ch++) begin
                scaled[ch*COLR_W +: COLR_W] <=
                    COLR_W'((PW'(colr[ch*COLR_W +: COLR_W]) * PW'(level)) >> SH);
            end
        end
    end

endmodule

// File: rtl/vga_layer_mixer.sv
// N-layer priority compositor with frame-counted cross-fade and a fixed 3-stage VGA output pipeline.
// Optional feature macro: MIXER_FADE_EN (fade FSM + scaler); undefined gives an instant switch.
module vga_layer_mixer
    import vga_mixer_pkg::*;
#(
    parameter int unsigned         N_LAYERS    = 2,
    parameter int unsigned         COLR_W      = 8,
    parameter logic [3*COLR_W-1:0] BG_COLR     = BG_DEFAULT,
    parameter int unsigned         FADE_FRAMES = 16
) (
    input logic              i_clk_pix,
    input logic              i_rst,
    vga_layer_mixer_if.slave bus
);
    localparam int unsigned      SEL_W = $clog2(N_LAYERS + 1);
    localparam int unsigned      CW    = 3 * COLR_W;
    localparam logic [SEL_W-1:0] NONE  = SEL_W'(layer_none(N_LAYERS));

    logic [SEL_W-1:0] req;
    logic [SEL_W-1:0] shown;
    logic             found;
    logic [CW-1:0]    pix;
    logic             hs1, vs1, de1, hs2, vs2, de2;
    logic [CW-1:0]    c1, c2;

    always_comb begin
        req   = NONE;
        found = 1'b0;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            if (!found && bus.i_processing[i]) begin
                req   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pix = BG_COLR;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            if (shown == SEL_W'(i) && bus.i_drawing[i]) pix = bus.i_colr[i*CW +: CW];
        end
    end

`ifdef MIXER_FADE_EN
    localparam int unsigned      LVL_W = $clog2(FADE_FRAMES) + 1;
    localparam logic [LVL_W-1:0] FULL  = LVL_W'(FADE_FRAMES);

    fade_state_e      state;
    logic [LVL_W-1:0] level, l1;

    // Leaving STEADY already takes the first step down, so a full switch spans 2*FADE_FRAMES pulses.
    always_ff @(posedge i_clk_pix or posedge i_rst) begin
        if (i_rst) begin
            state <= STEADY;
            level <= FULL;
            shown <= NONE;
        end else if (bus.i_frame) begin
            unique case (state)
                STEADY: begin
                    if (req != shown) begin
                        state <= FADE_OUT;
                        level <= level - LVL_W'(1);
                    end
                end
                FADE_OUT: begin
                    if (req == shown) begin
                        state <= FADE_IN;
                    end else if (level <= LVL_W'(1)) begin
                        level <= '0;
                        shown <= req;
                        state <= FADE_IN;
                    end else begin
                        level <= level - LVL_W'(1);
                    end
                end
                FADE_IN: begin
                    if (req != shown) begin
                        state <= FADE_OUT;
                    end else if (level >= FULL - LVL_W'(1)) begin
                        level <= FULL;
                        state <= STEADY;
                    end else begin
                        level <= level + LVL_W'(1);
                    end
                end
                default: state <= STEADY;
            endcase
        end
    end

    // Level travels with the pixel through stage 1 so a frame-edge change lands on the next pixel.
    always_ff @(posedge i_clk_pix or posedge i_rst) begin
        if (i_rst) l1 <= FULL;
        else       l1 <= level;
    end

    vga_fade_scaler #(
        .COLR_W      (COLR_W),
        .FADE_FRAMES (FADE_FRAMES)
    ) u_scaler (
        .clk    (i_clk_pix),
        .rst    (i_rst),
        .colr   (c1),
        .level  (l1),
        .scaled (c2)
    );

    assign bus.o_fading = (state != STEADY);
`else
    always_ff @(posedge i_clk_pix or posedge i_rst) begin
        if (i_rst)              shown <= NONE;
        else if (bus.i_frame)   shown <= req;
    end

    always_ff @(posedge i_clk_pix or posedge i_rst) begin
        if (i_rst) c2 <= '0;
        else       c2 <= c1;
    end

    assign bus.o_fading = 1'b0;
`endif

    assign bus.o_shown_layer = shown;
    assign bus.vga_sync_n    = 1'b1;

    always_ff @(posedge i_clk_pix or posedge i_rst) begin
        if (i_rst) begin
            hs1 <= 1'b0; vs1 <= 1'b0; de1 <= 1'b0; c1 <= '0;
            hs2 <= 1'b0; vs2 <= 1'b0; de2 <= 1'b0;
            bus.vga_hsync   <= 1'b0;
            bus.vga_vsync   <= 1'b0;
            bus.vga_blank_n <= 1'b0;
            bus.vga_r       <= '0;
            bus.vga_g       <= '0;
            bus.vga_b       <= '0;
        end else begin
            hs1 <= bus.i_hsync;
            vs1 <= bus.i_vsync;
            de1 <= bus.i_de;
            c1  <= bus.i_de ? pix : '0;
            hs2 <= hs1;
            vs2 <= vs1;
            de2 <= de1;
            bus.vga_hsync   <= hs2;
            bus.vga_vsync   <= vs2;
            bus.vga_blank_n <= de2;
            bus.vga_r       <= c2[CW-1 -: COLR_W];
            bus.vga_g       <= c2[2*COLR_W-1 -: COLR_W];
            bus.vga_b       <= c2[COLR_W-1:0];
        end
    end

endmodule

// File: doc/vga_layer_mixer.md
# vga_layer_mixer

- Parametrised N-layer compositor and VGA output stage.
- Sits between the display timing generator and the VGA pins, replacing the hand-written two-layer mux in the top level.
- Selects the highest-priority processing layer and draws that layer's opaque pixels over a fixed background colour.
- On every change of active layer it performs a frame-counted fade-out/fade-in, then drives registered VGA sync, blank and colour outputs with fixed latency.

## Interface

Parameters:
- N_LAYERS, 2: number of layers; index 0 has highest priority.
- COLR_W, 8: bits per colour channel.
- BG_COLR, 24'h6BE9F2: background RGB, packed {r,g,b}; COLR_W=8 assumed for this default.
- FADE_FRAMES, 16: frames per fade half; power of two, at least 2.

Ports:
- i_clk_pix  in  1  pixel clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_hsync  in  1  horizontal sync from timing generator.
- i_vsync  in  1  vertical sync from timing generator.
- i_de  in  1  data enable from timing generator.
- i_frame  in  1  one-cycle pulse at frame start.
- i_processing  in  N_LAYERS  layer i owns the screen.
- i_drawing  in  N_LAYERS  layer i pixel is opaque.
- i_colr  in  N_LAYERS*3*COLR_W  layer i RGB at bits [i*3*COLR_W +: 3*COLR_W], packed {r,g,b}.
- vga_hsync  out  1  delayed i_hsync.
- vga_vsync  out  1  delayed i_vsync.
- vga_blank_n  out  1  delayed i_de.
- vga_sync_n  out  1  constant 1.
- vga_r  out  COLR_W  red channel.
- vga_g  out  COLR_W  green channel.
- vga_b  out  COLR_W  blue channel.
- o_shown_layer  out  $clog2(N_LAYERS+1)  layer currently composited; value N_LAYERS means NONE.
- o_fading  out  1  FSM is not in STEADY.

## Operation

- **Requested layer (req):** lowest index i with i_processing[i]=1. NONE if no bit is set.
- **Pixel colour:** if shown≠NONE and i_drawing[shown], use i_colr[shown]; otherwise use BG_COLR.
- **Fade level L:** range 0..FADE_FRAMES. Each channel is output as (c*L) >> log2(FADE_FRAMES).
  - Product width is COLR_W+log2(FADE_FRAMES)+1, so there is no overflow.
  - L=FADE_FRAMES gives c exactly.
- **FSM states:** STEADY, FADE_OUT, FADE_IN. State, shown and L update only on cycles with i_frame=1.
  - STEADY: if req≠shown, go to FADE_OUT.
  - FADE_OUT: if req==shown, go to FADE_IN without changing L. Otherwise decrement L. When the decrement reaches 0, latch shown=req and go to FADE_IN.
  - FADE_IN: if req≠shown, go to FADE_OUT, continuing from the current L. Otherwise increment L. When L reaches FADE_FRAMES, go to STEADY.
- **Reset values:**
  - FSM: STEADY, L=FADE_FRAMES, shown=NONE.
  - Outputs: all VGA outputs 0 except vga_sync_n=1; o_shown_layer=NONE; o_fading=0.
- **Reset mid-fade:** returns immediately to the reset state; no partial fade survives.
- **Requests inside a frame:** req may change at any cycle. Only its value at the i_frame cycle is acted on.
- **Blanking:** when i_de=0, colour outputs are 0 at their pipeline slot, independent of L.

## Timing

- Fixed 3-cycle latency from i_hsync/i_vsync/i_de/i_drawing/i_colr to the vga_* outputs. All signals stay aligned.
  - Stage 1: register layer select plus sync/de.
  - Stage 2: register scaled product.
  - Stage 3: output register.
- L, shown and state change at most once per frame. The new values take effect on the first pixel after the i_frame cycle, and reach the outputs 3 cycles later.
- A full layer switch from STEADY at full level takes 2*FADE_FRAMES i_frame pulses.

## Configuration

- Macro MIXER_FADE_EN.
- Defined: fade FSM and scaler are present, as described above.
- Undefined:
  - shown=req is registered on each i_frame.
  - L is constant FADE_FRAMES, and the multiplier is removed.
  - o_fading is tied to 0.
  - Latency stays 3 cycles, so downstream timing is identical.

## Structure

- Package vga_mixer_pkg holds:
  - rgb_t packed struct {r,g,b} with COLR_W=8.
  - fade_state_e enum {STEADY, FADE_OUT, FADE_IN}.
  - Helper function for the NONE encoding.
- Sub-module vga_fade_scaler: registered per-channel c*L >> shift. Occupies pipeline stage 2.

## Test plan

- **Reset:** assert i_rst mid-line with N_LAYERS=2 → all vga colour/sync outputs 0, vga_sync_n=1, o_shown_layer=2, o_fading=0.
- **Steady background:** no processing bits, i_de=1 → output 6B/E9/F2 exactly 3 cycles after input. With i_de=0 → 00/00/00.
- **Layer switch:** set i_processing=2'b01 from reset, FADE_FRAMES=16.
  - Brightness falls 16→0 over 16 frames; at L=8 the output is 35/74/79.
  - o_shown_layer then becomes 0; the fade-in takes 16 frames; o_fading drops on the 32nd pulse.
- **Priority:** i_processing=2'b11 with both layers drawing → layer 0 colour shown. Layer 1 i_colr change → no output change.
- **Reversal mid-fade:** in FADE_OUT at L=5, set req back to shown → FADE_IN, and L goes 5→6 on the next pulse.
- **Macro off:** build without MIXER_FADE_EN, then switch layers → shown updates on the next i_frame; latency is still 3; o_fading stays 0.
